// File: rtl/store_narrow_rmw_if.sv
// rtl/store_narrow_rmw_if.sv - control handshake and data memory port bundle for store_narrow_rmw
interface store_narrow_rmw_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  start, size, addr, wdata, mem_rdata, mem_ready,
        output busy, done, misalign_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output start, size, addr, wdata, mem_rdata, mem_ready,
        input  busy, done, misalign_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_narrow_rmw.sv
// rtl/store_narrow_rmw.sv - multicycle byte/halfword/word store unit with read-modify-write
module store_narrow_rmw #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    store_narrow_rmw_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_WR_REQ,
        S_FIN,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        illegal;
    logic [1:0]  lane;
    logic        half;
    logic [31:0] merged;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            size_q      <= 2'b00;
            wdata_q     <= 16'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        illegal = (bus.size == 2'b11)
               || (bus.size == 2'b01 && bus.addr[0])
               || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    end

    // Lane/half selection in memory bit order; only the low byte/halfword of wdata is stored.
    always_comb begin
        lane   = BIG_ENDIAN ? (2'd3 - addr_q[1:0]) : addr_q[1:0];
        half   = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
        merged = bus.mem_rdata;
        if (size_q == 2'b00) begin
            case (lane)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (half) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.addr;
                    size_d  = bus.size;
                    wdata_d = bus.wdata[15:0];
                    if (illegal) begin
                        state_d = S_ERR;
                    end else if (bus.size == 2'b10) begin
                        mem_wdata_d = bus.wdata;
                        state_d     = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (bus.mem_ready) begin
                    mem_wdata_d = merged;
                    state_d     = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (bus.mem_ready) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy         = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign bus.done         = (state_q == S_FIN);
    assign bus.misalign_err = (state_q == S_ERR);
    assign bus.mem_rd       = (state_q == S_RD_REQ);
    assign bus.mem_wr       = (state_q == S_WR_REQ);
    assign bus.mem_addr     = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// tb/tb_store_narrow_rmw.sv - self-checking bench for store_narrow_rmw, both lane orders side by side
module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    store_narrow_rmw_if if_be ();
    store_narrow_rmw_if if_le ();

    assign if_be.start = start;      assign if_le.start = start;
    assign if_be.size = size;        assign if_le.size = size;
    assign if_be.addr = addr;        assign if_le.addr = addr;
    assign if_be.wdata = wdata;      assign if_le.wdata = wdata;
    assign if_be.mem_rdata = mem_rdata; assign if_le.mem_rdata = mem_rdata;
    assign if_be.mem_ready = mem_ready; assign if_le.mem_ready = mem_ready;

    store_narrow_rmw #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst_n(rst_n), .bus(if_be.slave));
    store_narrow_rmw #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst_n(rst_n), .bus(if_le.slave));

    int checks = 0;
    int errors = 0;

    int          o_done_be, o_done_le, o_done_cyc, o_err_be, o_err_le, o_err_cyc;
    int          o_rd_cnt, o_wr_cnt, o_overlap, o_unstable, o_busy_cnt;
    logic [31:0] o_rd_addr, o_wr_addr, o_wd_be, o_wd_le;
    logic        o_end_busy;

    // Memory viewed as four bytes in address order; lane order only decides how they pack into a word.
    function automatic logic [31:0] ref_word(input bit be, input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [31:0] rd);
        logic [7:0]  mb [4];
        logic [31:0] r;
        int          off;
        if (sz == 2'b10) return wd;
        off = int'(a[1:0]);
        for (int k = 0; k < 4; k++) mb[k] = be ? rd[8*(3-k) +: 8] : rd[8*k +: 8];
        if (sz == 2'b00) begin
            mb[off] = wd[7:0];
        end else begin
            mb[off]   = be ? wd[15:8] : wd[7:0];
            mb[off+1] = be ? wd[7:0]  : wd[15:8];
        end
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be) r[8*(3-k) +: 8] = mb[k];
            else    r[8*k +: 8]     = mb[k];
        end
        return r;
    endfunction

    function automatic bit ref_illegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
    endfunction

    function automatic int ref_latency(input logic [1:0] sz, input int rd_w, input int wr_w);
        return (sz == 2'b10) ? 2 + wr_w : 3 + rd_w + wr_w;
    endfunction

    // Drives one store from the current negedge and records what both DUTs do; memory waits per request.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdv, input int rd_w, input int wr_w, input bit restart);
        int rd_left = rd_w;
        int wr_left = wr_w;
        int end_c   = -1;
        o_done_be = 0; o_done_le = 0; o_done_cyc = -1; o_err_be = 0; o_err_le = 0; o_err_cyc = -1;
        o_rd_cnt = 0; o_wr_cnt = 0; o_overlap = 0; o_unstable = 0; o_busy_cnt = 0;
        o_rd_addr = 'x; o_wr_addr = 'x; o_wd_be = 'x; o_wd_le = 'x; o_end_busy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (if_be.done) begin o_done_be++; o_done_cyc = c; end
            if (if_le.done) o_done_le++;
            if (if_be.misalign_err) begin o_err_be++; o_err_cyc = c; end
            if (if_le.misalign_err) o_err_le++;
            if (if_be.busy) o_busy_cnt++;
            if (if_be.mem_rd) begin o_rd_cnt++; o_rd_addr = if_be.mem_addr; end
            if (if_be.mem_wr || if_le.mem_wr) begin
                if (o_wr_cnt == 0) begin
                    o_wr_addr = if_be.mem_addr; o_wd_be = if_be.mem_wdata; o_wd_le = if_le.mem_wdata;
                end else if (if_be.mem_wdata !== o_wd_be || if_le.mem_wdata !== o_wd_le) begin
                    o_unstable++;
                end
                o_wr_cnt++;
            end
            if ((if_be.mem_rd && if_be.mem_wr) || (if_le.mem_rd && if_le.mem_wr)) o_overlap++;
            if (c == end_c) begin o_end_busy = if_be.busy; break; end
            if (end_c < 0 && (if_be.done || if_be.misalign_err)) end_c = c + 1;
            start = (c == 0) || (restart && (c <= 2 || c == end_c - 1));
            if (c == 0) begin
                size = sz; addr = a; wdata = wd;
            end else begin
                size = 2'b10; addr = (a ^ 32'h0000_1000) & ~32'h3; wdata = ~wd;
            end
            if (if_be.mem_rd) begin
                mem_rdata = rdv;
                if (rd_left > 0) begin mem_ready = 1'b0; rd_left--; end
                else mem_ready = 1'b1;
            end else if (if_be.mem_wr) begin
                mem_rdata = $urandom;
                if (wr_left > 0) begin mem_ready = 1'b0; wr_left--; end
                else mem_ready = 1'b1;
            end else begin
                mem_rdata = $urandom;
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({if_be.busy, if_be.done, if_be.misalign_err, if_be.mem_rd, if_be.mem_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl_be got %b exp 00000", {if_be.busy, if_be.done, if_be.misalign_err, if_be.mem_rd, if_be.mem_wr}); end
        checks++; if ({if_le.busy, if_le.done, if_le.misalign_err, if_le.mem_rd, if_le.mem_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl_le got %b exp 00000", {if_le.busy, if_le.done, if_le.misalign_err, if_le.mem_rd, if_le.mem_wr}); end
        checks++; if (if_be.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", if_be.mem_addr); end
        checks++; if (if_be.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata_be got %h exp 0", if_be.mem_wdata); end
        checks++; if (if_le.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata_le got %h exp 0", if_le.mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        do_store(2'b10, 32'h100, 32'hDEADBEEF, $urandom, 0, 0, 1'b0);
        checks++; if (o_rd_cnt !== 0) begin errors++; $display("FAIL word_no_read got %0d exp 0", o_rd_cnt); end
        checks++; if (o_wr_addr !== 32'h100) begin errors++; $display("FAIL word_addr got %h exp 00000100", o_wr_addr); end
        checks++; if (o_wd_be !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata_be got %h exp deadbeef", o_wd_be); end
        checks++; if (o_wd_le !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata_le got %h exp deadbeef", o_wd_le); end
        checks++; if (o_done_cyc !== 2 || o_done_be !== 1) begin
            errors++; $display("FAIL word_done got cyc %0d cnt %0d exp cyc 2 cnt 1", o_done_cyc, o_done_be); end
    endtask

    task automatic test_byte();
        do_store(2'b00, 32'h101, 32'h000000AB, 32'h11223344, 0, 0, 1'b0);
        checks++; if (o_rd_addr !== 32'h100) begin errors++; $display("FAIL byte_rd_addr got %h exp 00000100", o_rd_addr); end
        checks++; if (o_wd_be !== 32'h11AB3344) begin errors++; $display("FAIL byte_wdata_be got %h exp 11ab3344", o_wd_be); end
        checks++; if (o_wd_le !== ref_word(1'b0, 2'b00, 32'h101, 32'hAB, 32'h11223344)) begin
            errors++; $display("FAIL byte_wdata_le got %h exp %h", o_wd_le, ref_word(1'b0, 2'b00, 32'h101, 32'hAB, 32'h11223344)); end
        checks++; if (o_done_cyc !== 3) begin errors++; $display("FAIL byte_done_cyc got %0d exp 3", o_done_cyc); end
    endtask

    task automatic test_half_waits();
        do_store(2'b01, 32'h202, 32'hFFFF5566, 32'hAABBCCDD, 2, 0, 1'b0);
        checks++; if (o_wd_le !== 32'h5566CCDD) begin errors++; $display("FAIL half_wdata_le got %h exp 5566ccdd", o_wd_le); end
        checks++; if (o_wd_be !== ref_word(1'b1, 2'b01, 32'h202, 32'hFFFF5566, 32'hAABBCCDD)) begin
            errors++; $display("FAIL half_wdata_be got %h exp %h", o_wd_be, ref_word(1'b1, 2'b01, 32'h202, 32'hFFFF5566, 32'hAABBCCDD)); end
        checks++; if (o_rd_cnt !== 3) begin errors++; $display("FAIL half_rd_held got %0d exp 3", o_rd_cnt); end
        checks++; if (o_done_cyc !== 5) begin errors++; $display("FAIL half_done_cyc got %0d exp 5", o_done_cyc); end
    endtask

    task automatic test_misalign();
        logic [1:0]  szs [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] as  [3] = '{32'h103, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_store(szs[i], as[i], $urandom, $urandom, 0, 0, 1'b0);
            checks++; if (o_err_cyc !== 1 || o_err_be !== 1 || o_err_le !== 1) begin
                errors++; $display("FAIL misalign_err_%0d got cyc %0d cnt %0d/%0d exp cyc 1 cnt 1", i, o_err_cyc, o_err_be, o_err_le); end
            checks++; if (o_rd_cnt + o_wr_cnt !== 0 || o_done_be + o_done_le !== 0) begin
                errors++; $display("FAIL misalign_noaccess_%0d got acc %0d done %0d exp 0", i, o_rd_cnt + o_wr_cnt, o_done_be + o_done_le); end
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        start = 1'b1; size = 2'b10; addr = 32'h300; wdata = $urandom; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (if_be.mem_wr !== 1'b1) begin errors++; $display("FAIL rstmid_in_wr got %b exp 1", if_be.mem_wr); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({if_be.mem_wr, if_be.busy, if_le.mem_wr, if_le.busy} !== 4'b0) begin
            errors++; $display("FAIL rstmid_abandon got %b exp 0000", {if_be.mem_wr, if_be.busy, if_le.mem_wr, if_le.busy}); end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (if_be.done || if_le.done) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", dn); end
        do_store(2'b10, 32'h304, 32'h0BADF00D, $urandom, 0, 0, 1'b0);
        checks++; if (o_done_cyc !== 2 || o_wd_be !== 32'h0BADF00D || o_wr_addr !== 32'h304) begin
            errors++; $display("FAIL rstmid_after got cyc %0d wd %h addr %h exp 2 0badf00d 00000304", o_done_cyc, o_wd_be, o_wr_addr); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] wd = $urandom;
        logic [31:0] rd = $urandom;
        do_store(2'b00, 32'h40D, wd, rd, 1, 1, 1'b1);
        checks++; if (o_done_be !== 1 || o_done_le !== 1) begin
            errors++; $display("FAIL busy_one_done got %0d/%0d exp 1", o_done_be, o_done_le); end
        checks++; if (o_rd_addr !== 32'h40C || o_wr_addr !== 32'h40C) begin
            errors++; $display("FAIL busy_addr got %h/%h exp 0000040c", o_rd_addr, o_wr_addr); end
        checks++; if (o_wd_be !== ref_word(1'b1, 2'b00, 32'h40D, wd, rd)) begin
            errors++; $display("FAIL busy_wdata got %h exp %h", o_wd_be, ref_word(1'b1, 2'b00, 32'h40D, wd, rd)); end
        checks++; if (o_done_cyc !== 5 || o_end_busy !== 1'b0) begin
            errors++; $display("FAIL busy_latency got cyc %0d endbusy %b exp 5 0", o_done_cyc, o_end_busy); end
    endtask

    task automatic test_random_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            int          rw = $urandom_range(0, 2);
            int          ww = $urandom_range(0, 2);
            int          lat = ref_latency(sz, rw, ww);
            do_store(sz, a, wd, rd, rw, ww, 1'b0);
            if (ref_illegal(sz, a)) begin
                checks++; if (o_err_cyc !== 1 || o_done_be !== 0 || o_rd_cnt + o_wr_cnt !== 0) begin
                    errors++; $display("FAIL rand_err_%0d got cyc %0d done %0d acc %0d exp 1 0 0", i, o_err_cyc, o_done_be, o_rd_cnt + o_wr_cnt); end
            end else begin
                checks++; if (o_done_cyc !== lat || o_done_be !== 1 || o_done_le !== 1 || o_busy_cnt !== lat - 1) begin
                    errors++; $display("FAIL rand_timing_%0d got cyc %0d busy %0d exp %0d %0d", i, o_done_cyc, o_busy_cnt, lat, lat - 1); end
                checks++; if (o_wr_addr !== {a[31:2], 2'b00} || o_wd_be !== ref_word(1'b1, sz, a, wd, rd)
                              || o_wd_le !== ref_word(1'b0, sz, a, wd, rd)) begin
                    errors++; $display("FAIL rand_data_%0d got %h %h/%h exp %h %h/%h", i, o_wr_addr, o_wd_be, o_wd_le,
                                       {a[31:2], 2'b00}, ref_word(1'b1, sz, a, wd, rd), ref_word(1'b0, sz, a, wd, rd)); end
                checks++; if (o_overlap !== 0 || o_unstable !== 0 || o_rd_cnt !== ((sz == 2'b10) ? 0 : rw + 1)) begin
                    errors++; $display("FAIL rand_proto_%0d got ovl %0d unst %0d rd %0d", i, o_overlap, o_unstable, o_rd_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_waits();
        test_misalign();
        test_reset_mid();
        test_start_while_busy();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
Multicycle store-narrowing unit. It takes a 32-bit register value and writes only a byte, halfword or word of it into word-organised data memory. Sub-word stores use a read-modify-write sequence. It sits between the multicycle control FSM (start/done handshake) and the data memory port. It is the store-side counterpart of the load path's extension logic: it narrows register data, where the load path widens memory data.

Parameters:
BIG_ENDIAN, 1, byte lane order. 1: address offset 0 maps to bits [31:24]. 0: offset 0 maps to bits [7:0].

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request pulse from control FSM; sampled only in IDLE
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
addr  input  32  byte address of the store
wdata  input  32  register value; low byte or low halfword is the data stored for sub-word sizes
busy  output  1  high from the cycle after an accepted start until done/err is asserted
done  output  1  one-cycle pulse when the store has completed
misalign_err  output  1  one-cycle pulse on an illegal size or misaligned address; no memory access made
mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}
mem_rd  output  1  memory read request, held until mem_ready
mem_wr  output  1  memory write request, held until mem_ready
mem_wdata  output  32  merged write word, stable while mem_wr is high
mem_rdata  input  32  read data, valid in the cycle mem_ready is high with mem_rd
mem_ready  input  1  memory completes the current request in this cycle

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - busy, done, misalign_err, mem_rd and mem_wr go to 0.
  - mem_addr and mem_wdata go to 0.
  - Reset mid-transaction abandons the transaction; no done pulse is issued.
- States: IDLE, RD_REQ, WR_REQ, FIN, ERR.
- IDLE:
  - On start=1, latch addr, size and wdata into addr_q, size_q and wdata_q.
  - Next state by case:
    - Illegal: size=11, or halfword with addr[0]=1, or word with addr[1:0]!=0. Go to ERR.
    - Word store: go to WR_REQ with mem_wdata=wdata.
    - Byte or halfword store: go to RD_REQ.
- RD_REQ:
  - mem_rd=1, mem_addr driven.
  - On mem_ready=1, merge mem_rdata with the narrowed data into mem_wdata and go to WR_REQ. mem_rd drops in the next cycle.
- Merge rules (off = addr_q[1:0]):
  - Byte: lane index L = BIG_ENDIAN ? 3-off : off. Lane L (bits [8L+7:8L]) is replaced with wdata_q[7:0]; the other three lanes keep mem_rdata.
  - Halfword: half index H = BIG_ENDIAN ? 1-off[1] : off[1]. Bits [16H+15:16H] are replaced with wdata_q[15:0]; the other half keeps mem_rdata.
- WR_REQ:
  - mem_wr=1 and mem_wdata held.
  - On mem_ready=1, go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- ERR: misalign_err=1 for one cycle, busy=0, no mem_rd/mem_wr, then IDLE.
- Protocol constraints:
  - mem_rd and mem_wr are never high in the same cycle.
  - Request outputs hold indefinitely while mem_ready=0; there is no timeout.
  - mem_ready while no request is pending is ignored.
- start while not in IDLE (including FIN and ERR) is ignored; it is not queued.
- Latency with zero-wait memory (mem_ready tied high), counted from the start cycle:
  - Word: done 2 cycles after start.
  - Byte/halfword: done 3 cycles after start.
  - Each memory wait cycle adds 1.
- Back-to-back: a new start is accepted in the cycle after done (IDLE).

Test Plan:
- Word store, BIG_ENDIAN=1, addr=0x100, wdata=0xDEADBEEF, mem_ready=1 -> no mem_rd; mem_wr=1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; done 2 cycles after start.
- Byte store, BIG_ENDIAN=1, addr=0x101, wdata=0x000000AB, read returns 0x11223344 -> mem_addr=0x100; write of 0x11AB3344; done at cycle 3.
- Halfword store, BIG_ENDIAN=0, addr=0x202, wdata=0xFFFF5566, read returns 0xAABBCCDD with 2 wait cycles -> write of 0x5566CCDD; done at cycle 5; mem_rd held through the waits.
- Misaligned cases: halfword at addr=0x103, word at addr=0x102, size=11 -> each gives a misalign_err pulse one cycle after start; mem_rd/mem_wr stay 0; no done.
- rst_n low during WR_REQ with mem_ready=0 -> next cycle mem_wr=0, busy=0, done never pulses; a following word store completes normally.
- start pulsed again while busy -> ignored; exactly one done pulse; mem_addr is unchanged from the first request.
